adc_serial_capture: RTL and testbench
=====================================

# adc_serial_capture

Requester side of the ADC clock handshake. On a start pulse it raises `clock_to_ADC_req` so the ADC clock generator drives a gated 5 MHz clock to the ADC. It then deserializes one `DATA_W`-bit sample from the ADC serial output, clocked by the returned 5 MHz clock, and presents the sample with a one-cycle valid strobe. It runs entirely in the 200 MHz domain and treats the 5 MHz clock as a sampled data signal.

## Interface

Parameters:
- `DATA_W`, 16, bits per ADC sample (2..32), MSB first.
- `TIMEOUT`, 1023, 200 MHz cycles allowed between consecutive ADC clock rising edges before abort.

Ports:
- `clk_200MHz_i`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle request to capture one sample.
- `adc_clk_i`  in  1  gated 5 MHz clock returned by the ADC clock generator (asynchronous to this block).
- `adc_sdo_i`  in  1  ADC serial data, stable around `adc_clk_i` rising edge.
- `clock_to_ADC_req`  out  1  request to the ADC clock generator; high for the whole transfer.
- `reset_ADC_signal`  out  1  one-cycle pulse that resets the ADC clock generator after an abort.
- `sample_o`  out  DATA_W  last completed sample; holds its value between captures.
- `sample_valid_o`  out  1  one-cycle strobe; `sample_o` is new in that cycle.
- `busy_o`  out  1  high in every state except IDLE.
- `timeout_err_o`  out  1  sticky abort flag.

## Operation

- Input conditioning: `adc_clk_i` and `adc_sdo_i` each pass through a 2-FF synchronizer, using identical depth so they stay aligned.
  - A third register on the synchronized clock gives `rise = s2 & ~s3`.
  - The data bit used is the synchronized `adc_sdo_i` in the `rise` cycle.
- State machine: IDLE, REQ, SHIFT, DONE, ABORT.
  - IDLE: `start_i`=1 moves to REQ. The bit counter and timeout counter clear, and `timeout_err_o` clears.
  - REQ: `clock_to_ADC_req`=1. The first `rise` shifts bit 0 (the MSB) and moves to SHIFT with the bit count at 1.
  - SHIFT: each `rise` shifts left, with the new bit entering the LSB, and increments the bit count. When the `rise` brings the count to `DATA_W`, the shift result loads `sample_o` and the state moves to DONE.
  - DONE: `sample_valid_o`=1 and `clock_to_ADC_req`=0 for exactly one cycle, then the state returns to IDLE.
  - ABORT: `reset_ADC_signal`=1 and `clock_to_ADC_req`=0 for one cycle, then the state returns to IDLE. `timeout_err_o` is set here and held until the next accepted `start_i`.
- Timeout (REQ, SHIFT):
  - The counter clears on every `rise` and increments otherwise.
  - When the counter reaches `TIMEOUT`, the state moves to ABORT.
  - `sample_o` is not updated on abort, and partial shift data is discarded.
- Boundary cases:
  - `start_i` outside IDLE is ignored; it is not queued.
  - `start_i` in the DONE cycle is ignored.
  - If a `rise` and a timeout occur in the same cycle, the `rise` wins and the counter clears.
  - The bit counter is `$clog2(DATA_W+1)` wide and never wraps.
- Reset: asserted at any time, including mid-transfer, it forces IDLE on the next edge.
  - All outputs go to 0, including `sample_o`.
  - The synchronizers and counters clear.

## Timing

- `start_i` sampled in cycle N puts `clock_to_ADC_req` high in cycle N+1.
- An external `adc_clk_i` rising edge produces `rise` 3 cycles later, ±1 cycle for metastability resolution.
- The last `rise` is in cycle M. `sample_o` and `sample_valid_o` update in M+1, `clock_to_ADC_req` drops in M+1, and `busy_o` drops in M+2.
- At 5 MHz the edge spacing is 40 cycles, so a 16-bit sample takes about 16×40 cycles plus the generator's start latency.
- `TIMEOUT` must exceed both the generator's start latency and 40.
- A back-to-back capture is possible with `start_i` in cycle M+2.

## Configuration

- `ADC_CAPTURE_TIMEOUT_EN` defined: timeout counter and ABORT state are present as described above.
- Not defined: the timeout counter and ABORT state are removed.
  - The block waits indefinitely in REQ and SHIFT; only `reset` recovers it.
  - `reset_ADC_signal` and `timeout_err_o` are tied to 0.
  - `TIMEOUT` is unused.

## Test plan

- Basic capture: reset, `start_i` pulse, then model a 5 MHz clock gated by `clock_to_ADC_req` with data 0xA5C3 MSB first.
  - Required: exactly one `sample_valid_o` pulse with `sample_o`=0xA5C3.
  - Required: `clock_to_ADC_req` low in the same cycle as the pulse.
- Back-to-back: capture 0x0001, then assert `start_i` 1 cycle after `busy_o` falls and capture 0xFFFF.
  - Required: two valid pulses, values 0x0001 then 0xFFFF, with no extra pulses.
- Ignored start: pulse `start_i` during SHIFT.
  - Required: the capture completes unchanged, followed by a single valid pulse and no second request.
- Timeout (macro on, `TIMEOUT`=100): the ADC clock stops after 5 edges.
  - Required: `reset_ADC_signal` is a 1-cycle pulse 100 cycles after the last `rise`.
  - Required: `timeout_err_o`=1, `sample_o` unchanged, no valid pulse.
  - Required: the next `start_i` clears `timeout_err_o`.
- Reset mid-transfer: assert `reset` after 8 bits.
  - Required: all outputs 0 on the next edge.
  - Required: a following capture of 0x1234 returns 0x1234.
- Macro off: stop the ADC clock.
  - Required: `busy_o` stays 1 for 5000 cycles, and `reset_ADC_signal` and `timeout_err_o` stay 0.

Source files
------------

// File: rtl/adc_serial_capture.sv
// -----------------------------------------------------------------------------
// adc_serial_capture
//
// Requester side of the ADC clock handshake. A start pulse raises
// clock_to_ADC_req so the external generator gates a 5 MHz clock to the ADC.
// That clock comes back on adc_clk_i. It is treated purely as data: it is
// synchronized into the 200 MHz domain and edge-detected. DATA_W bits are
// shifted in MSB first. The finished word is presented on sample_o, together
// with a one-cycle sample_valid_o strobe.
//
// Optional feature macro: ADC_CAPTURE_TIMEOUT_EN
//   defined     : watchdog between ADC clock edges, ABORT state,
//                 reset_ADC_signal pulse and sticky timeout_err_o.
//   not defined : no watchdog; the block waits for edges indefinitely,
//                 reset_ADC_signal and timeout_err_o are tied low.
//
// Parameters
//   DATA_W   bits per sample (2..32), MSB first
//   TIMEOUT  200 MHz cycles allowed between ADC clock rising edges
//
// Ports
//   clk_200MHz_i      system clock, rising edge
//   reset             synchronous active-high reset
//   start_i           one-cycle capture request (honoured only in IDLE)
//   adc_clk_i         returned gated ADC clock (asynchronous)
//   adc_sdo_i         ADC serial data
//   clock_to_ADC_req  clock request, high for the whole transfer
//   reset_ADC_signal  one-cycle generator reset after an abort
//   sample_o          last completed sample, held between captures
//   sample_valid_o    one-cycle strobe, sample_o is new in that cycle
//   busy_o            high in every state except IDLE
//   timeout_err_o     sticky abort flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module adc_serial_capture #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_200MHz_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              adc_clk_i,
  input  logic              adc_sdo_i,
  output logic              clock_to_ADC_req,
  output logic              reset_ADC_signal,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Elaboration-time parameter sanity checks.
  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
    $error("adc_serial_capture: DATA_W must be within 2..32");
  end
  if (TIMEOUT <= 40) begin : g_bad_timeout
    $error("adc_serial_capture: TIMEOUT must exceed the 40-cycle ADC clock period");
  end

`ifdef ADC_CAPTURE_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SHIFT, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SHIFT, S_DONE} state_t;
`endif

  state_t state_q, state_n;

  logic              clk_sync_p0, clk_sync_p1, clk_sync_p2;
  logic              sdo_sync_p0, sdo_sync_p1;
  logic              rise;
  logic              sdo_bit;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;

  // ---- stage p0/p1: two-flop synchronizers, p2: edge-detect delay ----------
  // Clock and data use the same depth, so the data bit seen in the rise
  // cycle is the one that was on the wire at the ADC clock edge.
  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      clk_sync_p0 <= 1'b0;
      clk_sync_p1 <= 1'b0;
      clk_sync_p2 <= 1'b0;
      sdo_sync_p0 <= 1'b0;
      sdo_sync_p1 <= 1'b0;
    end else begin
      clk_sync_p0 <= adc_clk_i;
      clk_sync_p1 <= clk_sync_p0;
      clk_sync_p2 <= clk_sync_p1;
      sdo_sync_p0 <= adc_sdo_i;
      sdo_sync_p1 <= sdo_sync_p0;
    end
  end

  assign rise       = clk_sync_p1 & ~clk_sync_p2;
  assign sdo_bit    = sdo_sync_p1;
  assign shift_next = {shift_q[DATA_W-2:0], sdo_bit};

`ifdef ADC_CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_expire;

  // The state leaves on the edge where the counter would reach TIMEOUT.
  // The FSM checks rise first, so a coincident edge always wins.
  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        S_REQ, S_SHIFT: to_cnt_q <= rise ? '0 : to_cnt_q + TO_W'(1);
        default:        to_cnt_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      timeout_err_o <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      timeout_err_o <= 1'b0;
    end else if (state_n == S_ABORT) begin
      timeout_err_o <= 1'b1;
    end
  end

  assign reset_ADC_signal = (state_q == S_ABORT);
`else
  assign reset_ADC_signal = 1'b0;
  assign timeout_err_o    = 1'b0;
`endif

  // ---- control: state register ---------------------------------------------
  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n          = state_q;
    clock_to_ADC_req = 1'b0;
    sample_valid_o   = 1'b0;
    busy_o           = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_n = S_REQ;
      end
      S_REQ: begin
        clock_to_ADC_req = 1'b1;
        if (rise) state_n = S_SHIFT;
`ifdef ADC_CAPTURE_TIMEOUT_EN
        else if (to_expire) state_n = S_ABORT;
`endif
      end
      S_SHIFT: begin
        clock_to_ADC_req = 1'b1;
        if (rise) begin
          if (bit_cnt_q == LAST_BIT) state_n = S_DONE;
        end
`ifdef ADC_CAPTURE_TIMEOUT_EN
        else if (to_expire) state_n = S_ABORT;
`endif
      end
      S_DONE: begin
        sample_valid_o = 1'b1;
        state_n        = S_IDLE;
      end
`ifdef ADC_CAPTURE_TIMEOUT_EN
      S_ABORT: begin
        state_n = S_IDLE;
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---- bit counter and output sample ---------------------------------------
  // The count saturates at DATA_W because the FSM leaves SHIFT on that rise.
  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      bit_cnt_q <= '0;
      sample_o  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) bit_cnt_q <= '0;
        end
        S_REQ: begin
          if (rise) bit_cnt_q <= CNT_W'(1);
        end
        S_SHIFT: begin
          if (rise) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) sample_o <= shift_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---- shift register (data only, not reset) -------------------------------
  // The first bit loads over any stale contents. An aborted partial word is
  // simply left here and overwritten by the next capture.
  always_ff @(posedge clk_200MHz_i) begin
    if (rise && state_q == S_REQ) begin
      shift_q <= {{(DATA_W-1){1'b0}}, sdo_bit};
    end else if (rise && state_q == S_SHIFT) begin
      shift_q <= shift_next;
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
`timescale 1ns/1ps
module tb_adc_serial_capture;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 100;
  localparam int HALF    = 20;   // half period of the 5 MHz clock in 200 MHz cycles

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_i = 1'b0;
  logic              adc_clk_i = 1'b0;
  logic              adc_sdo_i = 1'b0;
  logic              clock_to_ADC_req;
  logic              reset_ADC_signal;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              busy_o;
  logic              timeout_err_o;

  adc_serial_capture #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_200MHz_i     (clk),
    .reset            (reset),
    .start_i          (start_i),
    .adc_clk_i        (adc_clk_i),
    .adc_sdo_i        (adc_sdo_i),
    .clock_to_ADC_req (clock_to_ADC_req),
    .reset_ADC_signal (reset_ADC_signal),
    .sample_o         (sample_o),
    .sample_valid_o   (sample_valid_o),
    .busy_o           (busy_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #2.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- output monitor, sampled 1 ns after each rising edge -----------------
  int                valid_cnt = 0;
  int                req_rises = 0;
  int                rstsig_cnt = 0;
  int                rstsig_cyc = 0;
  int                valid_req_overlap = 0;
  logic              req_d = 1'b0;
  logic [DATA_W-1:0] valid_q[$];

  always @(posedge clk) begin
    #1;
    if (sample_valid_o === 1'b1) begin
      valid_cnt++;
      valid_q.push_back(sample_o);
      if (clock_to_ADC_req !== 1'b0) valid_req_overlap++;
    end
    if (clock_to_ADC_req === 1'b1 && req_d !== 1'b1) req_rises++;
    req_d = clock_to_ADC_req;
    if (reset_ADC_signal === 1'b1) begin
      rstsig_cnt++;
      rstsig_cyc = cyc;
    end
  end

  // ---- reference model: bits presented at ADC clock edges, MSB first -------
  int sent_bits[$];
  int last_edge_cyc = 0;

  function automatic logic [DATA_W-1:0] model_sample();
    longint v = 0;
    for (int i = 0; i < DATA_W; i++) v = v * 2 + ((i < sent_bits.size()) ? sent_bits[i] : 0);
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] last_valid();
    if (valid_q.size() == 0) return 'x;
    return valid_q[valid_q.size()-1];
  endfunction

  // Gated ADC clock generator: waits for the request, then emits 'edges'
  // rising edges with data set up half a period before each one.
  task automatic gen(input logic [DATA_W-1:0] w, input int edges);
    int t = 0;
    while (clock_to_ADC_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("gen_req_seen", {31'b0, clock_to_ADC_req}, 32'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < edges; i++) begin
      adc_sdo_i = w[DATA_W-1-i];
      sent_bits.push_back(int'(w[DATA_W-1-i]));
      repeat (HALF) @(negedge clk);
      adc_clk_i     = 1'b1;
      last_edge_cyc = cyc;
      repeat (HALF) @(negedge clk);
      adc_clk_i = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    int t = 0;
    while (valid_cnt < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic capture(input logic [DATA_W-1:0] w, input string name);
    int v0;
    sent_bits.delete();
    v0 = valid_cnt;
    pulse_start();
    chk({name, "_req_after_start"}, {31'b0, clock_to_ADC_req}, 32'd1);
    chk({name, "_err_cleared"}, {31'b0, timeout_err_o}, 32'd0);
    gen(w, DATA_W);
    wait_valid(v0 + 1);
    chk({name, "_valid_pulses"}, valid_cnt - v0, 32'd1);
    chk({name, "_sample"}, last_valid(), model_sample());
    chk({name, "_sample_held"}, sample_o, model_sample());
    chk({name, "_busy_done"}, {31'b0, busy_o}, 32'd0);
    chk({name, "_req_during_valid"}, valid_req_overlap, 32'd0);
  endtask

  typedef struct {
    string             name;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] prev;
    int v0, r0, p0, t, busy_low, err_seen;

    vecs[0] = '{"basic_a5c3", 16'hA5C3, 16'hA5C3};
    vecs[1] = '{"one",        16'h0001, 16'h0001};
    vecs[2] = '{"ones",       16'hFFFF, 16'hFFFF};
    vecs[3] = '{"zeros",      16'h0000, 16'h0000};
    vecs[4] = '{"msb_only",   16'h8000, 16'h8000};
    vecs[5] = '{"alt_5555",   16'h5555, 16'h5555};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",    {31'b0, clock_to_ADC_req}, 32'd0);
    chk("rst_rstsig", {31'b0, reset_ADC_signal}, 32'd0);
    chk("rst_valid",  {31'b0, sample_valid_o},   32'd0);
    chk("rst_busy",   {31'b0, busy_o},           32'd0);
    chk("rst_err",    {31'b0, timeout_err_o},    32'd0);
    chk("rst_sample", sample_o, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven captures
    for (int i = 0; i < 6; i++) begin
      capture(vecs[i].word, vecs[i].name);
      chk({vecs[i].name, "_table_exp"}, last_valid(), vecs[i].exp);
    end

    // Randomized captures against the model
    for (int i = 0; i < 4; i++) begin
      w = DATA_W'($urandom_range(0, 65535));
      capture(w, $sformatf("rand%0d", i));
    end

    // Back-to-back: restart in the first cycle busy_o is low
    sent_bits.delete();
    v0 = valid_cnt;
    r0 = req_rises;
    pulse_start();
    fork
      begin
        gen(16'h0001, DATA_W);
        gen(16'hFFFF, DATA_W);
      end
      begin
        t = 0;
        while (busy_o !== 1'b0 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    wait_valid(v0 + 2);
    chk("b2b_valid_pulses", valid_cnt - v0, 32'd2);
    chk("b2b_first",  (valid_q.size() >= 2) ? valid_q[valid_q.size()-2] : 'x, 32'h0001);
    chk("b2b_second", last_valid(), 32'hFFFF);
    chk("b2b_req_rises", req_rises - r0, 32'd2);
    chk("b2b_req_during_valid", valid_req_overlap, 32'd0);

    // Ignored start during SHIFT
    w = 16'h3C96;
    sent_bits.delete();
    v0 = valid_cnt;
    r0 = req_rises;
    pulse_start();
    fork
      gen(w, DATA_W);
      begin
        repeat (200) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    chk("ign_valid_pulses", valid_cnt - v0, 32'd1);
    chk("ign_sample", last_valid(), model_sample());
    chk("ign_req_rises", req_rises - r0, 32'd1);
    chk("ign_busy", {31'b0, busy_o}, 32'd0);

    // Reset after 8 bits
    sent_bits.delete();
    pulse_start();
    gen(16'hBEEF, 8);
    repeat (5) @(negedge clk);
    chk("mid_busy_before_reset", {31'b0, busy_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req",    {31'b0, clock_to_ADC_req}, 32'd0);
    chk("mid_rst_busy",   {31'b0, busy_o},           32'd0);
    chk("mid_rst_valid",  {31'b0, sample_valid_o},   32'd0);
    chk("mid_rst_sample", sample_o, 32'd0);
    chk("mid_rst_err",    {31'b0, timeout_err_o},    32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    capture(16'h1234, "after_reset");
    chk("after_reset_1234", last_valid(), 32'h1234);

`ifdef ADC_CAPTURE_TIMEOUT_EN
    // ADC clock stops after 5 edges
    prev = sample_o;
    v0   = valid_cnt;
    p0   = rstsig_cnt;
    sent_bits.delete();
    pulse_start();
    gen(16'hCAFE, 5);
    t = 0;
    while (rstsig_cnt == p0 && t < TIMEOUT + 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk("to_rstsig_pulses", rstsig_cnt - p0, 32'd1);
    // edge -> rise is 2..3 cycles through the synchronizer, then TIMEOUT idle cycles
    chk($sformatf("to_delay_%0d", rstsig_cyc - last_edge_cyc),
        {31'b0, (rstsig_cyc - last_edge_cyc >= TIMEOUT + 2) && (rstsig_cyc - last_edge_cyc <= TIMEOUT + 4)},
        32'd1);
    chk("to_err_set", {31'b0, timeout_err_o}, 32'd1);
    chk("to_sample_kept", sample_o, prev);
    chk("to_no_valid", valid_cnt - v0, 32'd0);
    chk("to_idle", {31'b0, busy_o}, 32'd0);
    capture(16'h0F0F, "after_timeout");
`else
    // No watchdog: the block waits forever without an ADC clock
    p0       = rstsig_cnt;
    busy_low = 0;
    err_seen = 0;
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b1) busy_low++;
      if (timeout_err_o !== 1'b0) err_seen++;
    end
    chk("nto_busy_low_cycles", busy_low, 32'd0);
    chk("nto_rstsig_pulses", rstsig_cnt - p0, 32'd0);
    chk("nto_err_cycles", err_seen, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("nto_recovered_idle", {31'b0, busy_o}, 32'd0);
    capture(16'h0F0F, "after_stall");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
